serial_comp_decoder: RTL

- Receive-side counterpart of the serial 1's-complement converter.
- Takes a framed, LSB-first serial stream of complemented bits and restores the original bits.
- Deserialises them into a WIDTH-bit word and presents it on a valid/ready output.
- Sits between the serial link and the word-level consumer; detects frames of the wrong length.

---
 rtl/serial_comp_decoder_pkg.sv | 15 +
 rtl/serial_comp_decoder_comp_bit_dec.sv | 38 +++
 rtl/serial_comp_decoder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/serial_comp_decoder_pkg.sv
// Shared definitions for the serial complement decoder: FSM encoding and width limits.
// Used by both serial_comp_decoder and comp_bit_dec.
package serial_comp_decoder_pkg;

    localparam int unsigned COMP_WIDTH_MAX = 32;
    localparam int unsigned CntW           = $clog2(COMP_WIDTH_MAX + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StHold  = 2'd2,
        StDrain = 2'd3
    } state_e;

endpackage

// File: rtl/serial_comp_decoder_comp_bit_dec.sv
// Per-bit recovery for the serial complement decoder.
// SERIAL_COMP_TWOS_EN selects two's-complement decoding (seen_one flag); default is pure inversion.
module comp_bit_dec
    import serial_comp_decoder_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bit_i,
    input  logic accept_i,
    input  logic frame_start_i,
    output logic recovered_o
);

`ifdef SERIAL_COMP_TWOS_EN
    logic seen_one_q;
    logic seen_one;

    // The first bit of a frame must see a cleared flag even if the register is stale.
    always_comb begin
        seen_one    = frame_start_i ? 1'b0 : seen_one_q;
        recovered_o = seen_one ? ~bit_i : bit_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_one_q <= 1'b0;
        end else if (accept_i) begin
            seen_one_q <= seen_one | bit_i;
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = ^{clk, rst, accept_i, frame_start_i};
    assign recovered_o   = ~bit_i;
`endif

endmodule

// File: rtl/serial_comp_decoder.sv
// Framed LSB-first serial complement decoder with valid/ready word output and frame-length check.
// SERIAL_COMP_TWOS_EN (in comp_bit_dec) switches to two's-complement decoding.
module serial_comp_decoder
    import serial_comp_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             err_frame
);

    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   out_word_q, out_word_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q, err_d;
    logic               accept;
    logic               frame_start;
    logic               rec_bit;
    logic [WIDTH-1:0]   shifted;

    comp_bit_dec u_bit_dec (
        .clk           (clk),
        .rst           (rst),
        .bit_i         (in_data),
        .accept_i      (accept),
        .frame_start_i (frame_start),
        .recovered_o   (rec_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        shifted     = {rec_bit, shift_q[WIDTH-1:1]};
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d = shifted;
                    if (in_last) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d   = CntW'(1);
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                if (accept) begin
                    shift_d = shifted;
                    if (cnt_q == LastCnt) begin
                        cnt_d = '0;
                        if (in_last) begin
                            out_word_d  = shifted;
                            out_valid_d = 1'b1;
                            state_d     = StHold;
                        end else begin
                            state_d = StDrain;
                        end
                    end else if (in_last) begin
                        cnt_d   = '0;
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            StDrain: begin
                if (accept && in_last) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready    = (state_q != StHold);
        accept      = in_valid & in_ready;
        frame_start = accept & (state_q == StIdle);
        out_valid   = out_valid_q;
        out_word    = out_word_q;
        err_frame   = err_q;
    end

endmodule
